uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among N_REQ byte-stream requesters (debug console, PDU monitor, CPU MMIO, …). Sits between the requesters and the transmitter's tx_ready/tx_data/tx_rd handshake. It latches one byte per grant, offers it to the transmitter, and returns a one-cycle acknowledge to the owning requester. Optionally it holds the grant across a multi-byte message.

---
 rtl/uart_arb_pkg.sv | 7 +
 rtl/uart_tx_arbiter_rr_pick.sv | 17 +
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmitter arbiter.
package uart_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam logic [15:0] HOLD_TIMEOUT_DEF = 16'd8680;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACK, S_NEXT} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set bit of req searching upward from ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte streams.
// Define UART_ARB_LOCK_EN to hold the grant across a message (req_last) with HOLD_TIMEOUT release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          N_REQ        = N_REQ_DEF,
  parameter int          IDW          = $clog2(N_REQ),
  parameter logic [15:0] HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    uart_tx_ready,
  output logic [BYTE_W-1:0]       uart_tx_data,
  input  logic                    uart_tx_rd,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [IDW-1:0] ptr, ptr_n, grant_n, pick_idx, ptr_inc;
  logic [N_REQ-1:0] ack_n;
  logic [BYTE_W-1:0] data_n;
  logic ready_n, lock, lock_n, found;
  logic [15:0] cnt, cnt_n;
  rr_pick #(.N(N_REQ), .W(IDW)) u_pick (
    .req  (req_vld),
    .ptr  (ptr),
    .found(found),
    .idx  (pick_idx)
  );
  assign busy = state != S_IDLE;
  assign ptr_inc = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
  // lock stays 0 without LOCK_EN, so S_NEXT always re-arbitrates
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = grant_id;
    data_n = uart_tx_data;
    ready_n = uart_tx_ready;
    ack_n = '0;
    lock_n = lock;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (found) begin
        data_n = req_data[BYTE_W*pick_idx +: BYTE_W];
        grant_n = pick_idx;
        lock_n = LOCK_EN & ~req_last[pick_idx];
        cnt_n = '0;
        ready_n = 1'b1;
        state_n = S_OFFER;
      end
      S_OFFER: if (uart_tx_rd) begin
        ready_n = 1'b0;
        ack_n = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        state_n = S_ACK;
      end
      S_ACK: state_n = S_NEXT;
      default: if (!lock) begin
        ptr_n = ptr_inc;
        state_n = S_IDLE;
      end else if (req_vld[grant_id]) begin
        data_n = req_data[BYTE_W*grant_id +: BYTE_W];
        lock_n = LOCK_EN & ~req_last[grant_id];
        cnt_n = '0;
        ready_n = 1'b1;
        state_n = S_OFFER;
      end else if (cnt == HOLD_TIMEOUT - 16'd1) begin
        lock_n = 1'b0;
        ptr_n = ptr_inc;
        state_n = S_IDLE;
      end else begin
        cnt_n = cnt + 16'd1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      ptr <= '0;
      grant_id <= '0;
      uart_tx_data <= '0;
      uart_tx_ready <= 1'b0;
      req_ack <= '0;
      lock <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_id <= grant_n;
      uart_tx_data <= data_n;
      uart_tx_ready <= ready_n;
      req_ack <= ack_n;
      lock <= lock_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench; lock scenarios run when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] req_vld = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_last = '0;
  logic [3:0] req_ack;
  logic uart_tx_ready;
  logic [7:0] uart_tx_data;
  logic uart_tx_rd = 1'b0;
  logic busy;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;
  uart_tx_arbiter #(.N_REQ(4), .IDW(2), .HOLD_TIMEOUT(16'd8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ack      (req_ack),
    .uart_tx_ready(uart_tx_ready),
    .uart_tx_data (uart_tx_data),
    .uart_tx_rd   (uart_tx_rd),
    .busy         (busy),
    .grant_id     (grant_id)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask
  // waits for an offer, checks it, plays the transmitter, checks the ack pulse; ends in the S_NEXT cycle
  task automatic send(input string tag, input int id, input logic [7:0] d);
    int n = 0;
    while (!uart_tx_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, {31'd0, uart_tx_ready}, 32'd1);
    chk({tag, "_data"}, {24'd0, uart_tx_data}, {24'd0, d});
    chk({tag, "_gid"}, {30'd0, grant_id}, id);
    tick();
    uart_tx_rd = 1'b1;
    tick();
    uart_tx_rd = 1'b0;
    chk({tag, "_ack"}, {28'd0, req_ack}, 32'd1 << id);
    chk({tag, "_rdy0"}, {31'd0, uart_tx_ready}, 32'd0);
    tick();
    chk({tag, "_ack0"}, {28'd0, req_ack}, 32'd0);
  endtask
  initial begin
    tick();
    chk("rst_rdy", {31'd0, uart_tx_ready}, 32'd0);
    chk("rst_data", {24'd0, uart_tx_data}, 32'd0);
    chk("rst_ack", {28'd0, req_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    do_reset();
    // single byte, exact cycle timing
    req_vld = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    chk("one_rdy_c1", {31'd0, uart_tx_ready}, 32'd1);
    chk("one_data_c1", {24'd0, uart_tx_data}, 32'hA5);
    chk("one_busy_c1", {31'd0, busy}, 32'd1);
    tick();
    chk("one_rdy_c2", {31'd0, uart_tx_ready}, 32'd1);
    chk("one_ack_c2", {28'd0, req_ack}, 32'd0);
    uart_tx_rd = 1'b1;
    tick();
    uart_tx_rd = 1'b0;
    req_vld = 4'b0000;
    chk("one_ack_c3", {28'd0, req_ack}, 32'd1);
    chk("one_rdy_c3", {31'd0, uart_tx_ready}, 32'd0);
    tick();
    chk("one_ack_c4", {28'd0, req_ack}, 32'd0);
    chk("one_busy_c4", {31'd0, busy}, 32'd1);
    tick();
    chk("one_busy_c5", {31'd0, busy}, 32'd0);
    // spurious read strobe while idle
    uart_tx_rd = 1'b1;
    tick();
    uart_tx_rd = 1'b0;
    chk("spur_ack", {28'd0, req_ack}, 32'd0);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_rdy", {31'd0, uart_tx_ready}, 32'd0);
    tick();
    chk("spur_ack2", {28'd0, req_ack}, 32'd0);
    chk("spur_busy2", {31'd0, busy}, 32'd0);
    // round robin with everyone valid; wraps 3 -> 0
    do_reset();
    req_data = 32'h13121110;
    req_last = 4'b1111;
    req_vld = 4'b1111;
    send("rr0", 0, 8'h10);
    send("rr1", 1, 8'h11);
    send("rr2", 2, 8'h12);
    send("rr3", 3, 8'h13);
    send("rr4", 0, 8'h10);
    req_vld = 4'b0000;
    tick();
    tick();
    // reset while offering
    req_vld = 4'b0100;
    req_data[23:16] = 8'h77;
    tick();
    chk("ro_rdy", {31'd0, uart_tx_ready}, 32'd1);
    chk("ro_gid", {30'd0, grant_id}, 32'd2);
    rstn = 1'b0;
    #1;
    chk("ro_rdy0", {31'd0, uart_tx_ready}, 32'd0);
    chk("ro_ack0", {28'd0, req_ack}, 32'd0);
    chk("ro_gid0", {30'd0, grant_id}, 32'd0);
    chk("ro_busy0", {31'd0, busy}, 32'd0);
    tick();
    rstn = 1'b1;
    send("ro_again", 2, 8'h77);
    req_vld = 4'b0000;
    tick();
`ifdef UART_ARB_LOCK_EN
    // three-byte message from 2 while 0 waits
    do_reset();
    req_vld = 4'b0010;
    req_data = 32'h00000031;
    req_data[15:8] = 8'h31;
    req_last = 4'b0010;
    send("lk_pre", 1, 8'h31);
    req_vld = 4'b0101;
    req_data[7:0] = 8'h40;
    req_data[23:16] = 8'h21;
    req_last = 4'b0001;
    send("lk_b0", 2, 8'h21);
    req_data[23:16] = 8'h22;
    tick();
    chk("lk_b2b_rdy", {31'd0, uart_tx_ready}, 32'd1);
    send("lk_b1", 2, 8'h22);
    req_data[23:16] = 8'h23;
    req_last = 4'b0101;
    send("lk_b2", 2, 8'h23);
    req_vld = 4'b0001;
    send("lk_r0", 0, 8'h40);
    req_vld = 4'b0000;
    tick();
    // hold timeout after an unfinished message
    do_reset();
    req_vld = 4'b0010;
    req_data = 32'h33225511;
    req_last = 4'b0000;
    send("to", 1, 8'h55);
    req_vld = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    chk("to_busy_hold", {31'd0, busy}, 32'd1);
    tick();
    chk("to_busy_rel", {31'd0, busy}, 32'd0);
    req_vld = 4'b1111;
    req_last = 4'b1111;
    send("to_ptr", 2, 8'h22);
    req_vld = 4'b0000;
    tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
